// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_ID_rs1_addr,
  input  logic [4:0]       i_ID_rs2_addr,
  input  logic             i_ID_rs1_used,
  input  logic             i_ID_rs2_used,
  input  logic [4:0]       i_EX_rd_addr,
  input  logic             i_EX_rd_wren,
  input  logic             i_EX_is_load,
  input  logic             i_EX_mispred,
  input  logic             i_MEM_req,
  input  logic             i_MEM_ack,
  output logic             o_pc_en,
  output logic             o_IF_ID_en,
  output logic             o_IF_ID_flush,
  output logic             o_ID_EX_en,
  output logic             o_ID_EX_flush,
  output logic             o_EX_MEM_en,
  output logic             o_MEM_WB_bubble,
  output logic             o_mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  typedef enum logic {S_RUN, S_MEM_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;

  assign load_use = i_EX_is_load & i_EX_rd_wren & (i_EX_rd_addr != 5'd0) &
                    ((i_ID_rs1_used & (i_ID_rs1_addr == i_EX_rd_addr)) |
                     (i_ID_rs2_used & (i_ID_rs2_addr == i_EX_rd_addr)));
  assign mem_stall = i_MEM_req & ~i_MEM_ack;

  always_comb begin
    o_pc_en         = 1'b1;
    o_IF_ID_en      = 1'b1;
    o_IF_ID_flush   = 1'b0;
    o_ID_EX_en      = 1'b1;
    o_ID_EX_flush   = 1'b0;
    o_EX_MEM_en     = 1'b1;
    o_MEM_WB_bubble = 1'b0;
    if (i_rst) begin
      o_pc_en         = 1'b0;
      o_IF_ID_en      = 1'b0;
      o_IF_ID_flush   = 1'b1;
      o_ID_EX_en      = 1'b0;
      o_ID_EX_flush   = 1'b1;
      o_EX_MEM_en     = 1'b0;
      o_MEM_WB_bubble = 1'b1;
    end else if (mem_stall) begin
      // Whole pipe frozen; EX keeps any pending mispredict/load for release.
      o_pc_en         = 1'b0;
      o_IF_ID_en      = 1'b0;
      o_ID_EX_en      = 1'b0;
      o_EX_MEM_en     = 1'b0;
      o_MEM_WB_bubble = 1'b1;
    end else if (i_EX_mispred) begin
      o_IF_ID_flush   = 1'b1;
      o_ID_EX_flush   = 1'b1;
    end else if (load_use) begin
      o_pc_en         = 1'b0;
      o_IF_ID_en      = 1'b0;
      o_ID_EX_flush   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      o_mem_err <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (mem_stall) begin
            state    <= S_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        S_MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_ONE;
            // Error rises on the edge where the count reaches the limit.
            if (wait_cnt == WAIT_PRE) o_mem_err <= 1'b1;
          end else begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (mem_stall | load_use) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (i_EX_mispred & ~mem_stall) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline (Gshare variant).
- Drives the enable, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Inputs: load-use hazards from ID/EX, mispredict redirects from EX, and a req/ack handshake from the MEM-stage LSU.
- Tracks LSU wait cycles with a state machine, a timeout counter and a sticky error flag.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before o_mem_err sets (legal range 2..65535)
CNT_W, 32, width of performance counters

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_ID_rs1_addr  in  5  rs1 of instruction in ID
i_ID_rs2_addr  in  5  rs2 of instruction in ID
i_ID_rs1_used  in  1  ID instruction reads rs1
i_ID_rs2_used  in  1  ID instruction reads rs2
i_EX_rd_addr  in  5  rd of instruction in EX
i_EX_rd_wren  in  1  EX instruction writes rd
i_EX_is_load  in  1  EX instruction is a load
i_EX_mispred  in  1  EX resolved branch/jump mispredicted
i_MEM_req  in  1  LSU access active in MEM
i_MEM_ack  in  1  LSU access completes this cycle
o_pc_en  out  1  PC update enable
o_IF_ID_en  out  1  IF/ID load enable
o_IF_ID_flush  out  1  IF/ID clear to bubble
o_ID_EX_en  out  1  ID/EX load enable
o_ID_EX_flush  out  1  ID/EX clear to bubble
o_EX_MEM_en  out  1  EX/MEM load enable
o_MEM_WB_bubble  out  1  MEM/WB loads insn_vld=0, rd_wren=0
o_mem_err  out  1  sticky LSU timeout flag

Behaviour:
- Outputs are combinational from inputs and registered state. Registered state: FSM, wait counter, error flag, perf counters.
- Reset (i_rst=1, async):
  - FSM=RUN, wait_cnt=0, o_mem_err=0, counters=0.
  - While held: all _en=0, both flushes=1, o_MEM_WB_bubble=1.
- load_use = i_EX_is_load & i_EX_rd_wren & (i_EX_rd_addr!=0) & ((i_ID_rs1_used & rs1==rd) | (i_ID_rs2_used & rs2==rd)).
- mem_stall = i_MEM_req & ~i_MEM_ack.
- Priority, highest first:
  1. mem_stall:
     - pc_en, IF_ID_en, ID_EX_en, EX_MEM_en = 0.
     - Flushes = 0.
     - MEM_WB_bubble = 1.
     - Pending mispredict/load-use is held; EX is frozen, so it is re-evaluated on release.
  2. i_EX_mispred:
     - pc_en=1 (PC loads redirect), IF_ID_flush=1, ID_EX_flush=1.
     - All _en=1, bubble=0.
     - Suppresses load_use, since ID holds a wrong-path instruction.
  3. load_use:
     - pc_en=0, IF_ID_en=0, ID_EX_flush=1; ID_EX_en, EX_MEM_en = 1.
     - Lasts exactly one cycle, because the next cycle EX holds the bubble.
  4. Otherwise: all _en=1, flushes=0, bubble=0.
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt <= 1.
  - MEM_WAIT: wait_cnt increments while mem_stall, saturating at MEM_TIMEOUT.
  - MEM_WAIT -> RUN when i_MEM_ack=1 or i_MEM_req=0. The release cycle follows the normal priority; wait_cnt <= 0.
  - req&ack in the same cycle from RUN: no stall, no state change.
- Timeout: wait_cnt reaching MEM_TIMEOUT sets o_mem_err=1 on that edge. It is sticky and cleared only by reset. The pipeline keeps stalling; the error does not force release.
- Reset asserted mid-wait: immediate return to RUN, counters and error cleared.
- rd=x0 never causes load-use.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined: adds o_stall_cnt[CNT_W] and o_flush_cnt[CNT_W] outputs.
  - stall_cnt increments each cycle with mem_stall or load_use.
  - flush_cnt increments each cycle with i_EX_mispred and no mem_stall.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX lw rd=5 (wren=1), ID rs2_used=1 rs2=5 -> one cycle pc_en=0, IF_ID_en=0, ID_EX_flush=1; next cycle (EX is_load=0) all _en=1.
- x0 / no-use: EX load rd=0 with ID rs1=0; then rd=7 with rs1_used=0 rs1=7 -> no stall either case.
- Mispredict + load_use same cycle -> IF_ID_flush=1, ID_EX_flush=1, pc_en=1; load-use suppressed.
- LSU wait: req=1, ack=0 for 3 cycles then ack=1 -> 3 cycles all _en=0 and bubble=1; FSM MEM_WAIT; release cycle all _en=1, FSM back to RUN. A mispredict asserted during the wait flushes only on the release cycle.
- Timeout: MEM_TIMEOUT=4, req=1, ack=0 for 6 cycles -> o_mem_err=1 after 4th wait edge and stays 1 after ack. Pulse i_rst mid-wait -> FSM=RUN, o_mem_err=0 immediately.
- PIPE_HAZARD_PERF_EN: 2 load-use stalls + 3 wait cycles + 1 mispredict -> o_stall_cnt=5, o_flush_cnt=1.
